mem_req_master: RTL and testbench
=================================

Name: mem_req_master

Overview:
- Initiator side of the synchronous RAM port (cs/oe/we/sb/sh/lb/lh/addr/din/dout).
- Accepts load/store requests from the core over a valid/ready handshake, checks alignment, and drives exactly one RAM access per legal request.
- Waits out the RAM read latency, then sign- or zero-extends sub-word load data and returns a registered response.

Parameters:
- ADDR_W, 32, width of the request and RAM address.
- READ_LAT, 1, cycles after the issue edge before mem_dout is sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size
- mem_cs, mem_oe, mem_we  out  1 each  RAM chip select, read enable, write enable
- mem_sb, mem_sh, mem_lb, mem_lh  out  1 each  RAM store/load byte/half strobes
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data, zero-extended by RAM for lb/lh
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0 except req_ready = 1; state IDLE; latency counter 0. Reset mid-access aborts immediately; the response is dropped.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1. On req_valid at edge E0, latch we/size/signed/addr/wdata.
  - Error check: size 11; half with addr[0] = 1; word with addr[1:0] != 0. On error, go to RESP with resp_err = 1, rdata = 0, and no mem_* activity.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_cs = 1; mem_addr = latched addr; mem_din = latched wdata.
  - Store: mem_we = 1; mem_sb = size==00; mem_sh = size==01.
  - Load: mem_oe = 1; mem_lb = size==00; mem_lh = size==01.
  - All strobes are registered and return to 0 the following cycle.
  - Store goes to RESP at edge E1. Load goes to WAIT with counter = READ_LAT-1.
- WAIT:
  - Counter decrements each cycle. When the counter is 0, mem_dout is sampled at that edge and the FSM goes to RESP.
  - With READ_LAT = 1, dout is sampled at E2, so resp_valid rises after E2.
  - Extension: byte uses bit 7, half uses bit 15 when req_signed = 1; otherwise zero-extend. Word passes through.
- RESP:
  - resp_valid = 1; rdata and err are held stable until resp_ready.
  - On resp_valid & resp_ready the FSM returns to IDLE; req_ready rises the cycle after.
  - No request overlap: at most one outstanding access.
- Latency, with response ready tied high:
  - Legal store: resp_valid 2 edges after acceptance.
  - Legal load: 2 + READ_LAT edges after acceptance.
  - Error: 1 edge after acceptance.
- Outside ISSUE, mem_addr and mem_din hold their last value; mem_cs, mem_oe and mem_we are 0.

Optional Feature:
- MEM_REQ_PERF_CNT_EN defined:
  - Adds outputs perf_loads, perf_stores, perf_errs, each 32 bits.
  - Counts increment on the response handshake for legal load, legal store and error respectively.
  - Counters wrap at 2^32 and are cleared by rst_n.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store word addr 0x10, data 0xDEADBEEF -> one cycle with mem_cs = 1, mem_we = 1, sb = sh = 0, mem_addr = 0x10; resp_valid 2 edges later; rdata = 0; err = 0.
- Load byte signed addr 0x13, mem_dout = 0x00000080, READ_LAT = 1 -> mem_lb = 1 in ISSUE; rdata = 0xFFFFFF80 at 3 edges. Same access unsigned -> rdata = 0x00000080.
- Load half addr 0x21, and size 11 -> resp_err = 1 after 1 edge; mem_cs never asserted; rdata = 0.
- READ_LAT = 4, load word with mem_dout = 0x12345678 -> resp_valid 6 edges after acceptance; rdata = 0x12345678.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid/rdata stable; req_ready = 0; new req_valid ignored until the handshake.
- rst_n pulsed low during WAIT -> all mem_* = 0 and resp_valid = 0 asynchronously; req_ready = 1 after release; next load completes normally.

Source files
------------

// File: rtl/mem_req_master_if.sv
// rtl/mem_req_master_if.sv - core request/response and synchronous RAM port bundle for mem_req_master
// master: the request master itself; slave: the core and RAM side around it.
interface mem_req_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              mem_cs;
  logic              mem_oe;
  logic              mem_we;
  logic              mem_sb;
  logic              mem_sh;
  logic              mem_lb;
  logic              mem_lh;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_cs, mem_oe, mem_we, mem_sb, mem_sh, mem_lb, mem_lh, mem_addr, mem_din,
    input  mem_dout
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_cs, mem_oe, mem_we, mem_sb, mem_sh, mem_lb, mem_lh, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_req_master.sv
// rtl/mem_req_master.sv - single-outstanding load/store initiator for a synchronous RAM port
// Optional MEM_REQ_PERF_CNT_EN adds perf_loads/perf_stores/perf_errs handshake counters.
module mem_req_master #(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_req_master_if.master bus,
  output logic             busy
`ifdef MEM_REQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_loads,
  output logic [31:0]      perf_stores,
  output logic [31:0]      perf_errs
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic       lat_we;
  logic [1:0] lat_size;
  logic       lat_sgn;
  logic       req_bad;

  assign busy = (state != IDLE);

  assign req_bad = (bus.req_size == 2'b11) ||
                   ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  // The RAM already zero-extends lb/lh data; the mask keeps stray upper bits out anyway.
  function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_cnt        <= 4'd0;
      lat_we         <= 1'b0;
      lat_size       <= 2'b00;
      lat_sgn        <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      bus.mem_cs     <= 1'b0;
      bus.mem_oe     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_sb     <= 1'b0;
      bus.mem_sh     <= 1'b0;
      bus.mem_lb     <= 1'b0;
      bus.mem_lh     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_din    <= 32'd0;
    end else begin
      // Strobes are single-cycle pulses; only the IDLE->ISSUE transition raises them.
      bus.mem_cs <= 1'b0;
      bus.mem_oe <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_sb <= 1'b0;
      bus.mem_sh <= 1'b0;
      bus.mem_lb <= 1'b0;
      bus.mem_lh <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            lat_we        <= bus.req_we;
            lat_size      <= bus.req_size;
            lat_sgn       <= bus.req_signed;
            if (req_bad) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'd0;
            end else begin
              state        <= ISSUE;
              bus.mem_cs   <= 1'b1;
              bus.mem_addr <= bus.req_addr;
              bus.mem_din  <= bus.req_wdata;
              if (bus.req_we) begin
                bus.mem_we <= 1'b1;
                bus.mem_sb <= (bus.req_size == 2'b00);
                bus.mem_sh <= (bus.req_size == 2'b01);
              end else begin
                bus.mem_oe <= 1'b1;
                bus.mem_lb <= (bus.req_size == 2'b00);
                bus.mem_lh <= (bus.req_size == 2'b01);
              end
            end
          end
        end

        ISSUE: begin
          if (lat_we) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
          end else begin
            state   <= WAIT;
            lat_cnt <= 4'(READ_LAT - 1);
          end
        end

        WAIT: begin
          if (lat_cnt == 4'd0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= extend(lat_size, lat_sgn, bus.mem_dout);
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_REQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 32'd0;
      perf_stores <= 32'd0;
      perf_errs   <= 32'd0;
    end else if ((state == RESP) && bus.resp_ready) begin
      if (bus.resp_err)
        perf_errs <= perf_errs + 32'd1;
      else if (lat_we)
        perf_stores <= perf_stores + 32'd1;
      else
        perf_loads <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// tb/tb_mem_req_master.sv - scoreboard bench for mem_req_master, one lane at READ_LAT=1 and one at READ_LAT=4
module tb_mem_req_master;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          bp;
    bit          rst_mid;
  } txn_t;

  logic clk;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %h expected %h", lane, name, act, exp);
    end
  endtask

  // Expected outcome from the request alone: alignment rule, latency rule, extension by arithmetic.
  function automatic txn_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] dout, input int lat);
    txn_t t;
    int   v;
    t.we = we; t.size = size; t.sgn = sgn; t.addr = addr; t.wdata = wdata; t.dout = dout;
    t.acc = 0; t.bp = 0; t.rst_mid = 0;
    t.err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
            (size == 2'd2 && (addr % 4) != 0);
    t.lat = t.err ? 1 : (we ? 2 : 2 + lat);
    t.rdata = 32'd0;
    if (!t.err && !we) begin
      case (size)
        2'd0: begin
          v = int'(dout & 32'hFF);
          if (sgn && v >= 128) v = v - 256;
          t.rdata = 32'(v);
        end
        2'd1: begin
          v = int'(dout & 32'hFFFF);
          if (sgn && v >= 32768) v = v - 65536;
          t.rdata = 32'(v);
        end
        default: t.rdata = dout;
      endcase
    end
    return t;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 4;

    mem_req_master_if #(.ADDR_W(32)) bus ();
    logic rst_n;
    logic busy;
`ifdef MEM_REQ_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

    mem_req_master #(.ADDR_W(32), .READ_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
`ifdef MEM_REQ_PERF_CNT_EN
      ,
      .perf_loads  (perf_loads),
      .perf_stores (perf_stores),
      .perf_errs   (perf_errs)
`endif
    );

    txn_t q[$];
    txn_t plan[$];
    txn_t t;
    txn_t m;
    int   hold = 0;
    int   cs_seen = 0;
    bit   seen_v = 0;
    int   n_ld = 0, n_st = 0, n_er = 0;

    // Monitor: checks whatever the DUT presents against the head of the scoreboard.
    initial begin
      logic       rdy_n;
      logic [5:0] strb_exp;
      bus.resp_ready = 1'b0;
      forever begin
        @(negedge clk);
        rdy_n = ($urandom % 4) != 0;
        if (rst_n && q.size() > 0) begin
          m = q[0];
          if (bus.mem_cs) begin
            cs_seen++;
            strb_exp = m.we ? {1'b1, 1'b0, m.size == 2'd0, m.size == 2'd1, 2'b00}
                            : {1'b0, 1'b1, 2'b00, m.size == 2'd0, m.size == 2'd1};
            check(g, "mem_strobes", 32'({bus.mem_we, bus.mem_oe, bus.mem_sb, bus.mem_sh,
                                         bus.mem_lb, bus.mem_lh}), 32'(strb_exp));
            check(g, "mem_addr", bus.mem_addr, m.addr);
            check(g, "mem_din", bus.mem_din, m.wdata);
          end
          if (bus.resp_valid) begin
            if (hold > 0) begin
              rdy_n = 1'b0;
              hold--;
            end
            if (!seen_v) begin
              seen_v = 1'b1;
              check(g, "latency", 32'(cyc - m.acc + 1), 32'(m.lat));
            end
            check(g, "resp_rdata", bus.resp_rdata, m.rdata);
            check(g, "resp_err", 32'(bus.resp_err), 32'(m.err));
            check(g, "req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (rdy_n) begin
              check(g, "cs_cycles", 32'(cs_seen), m.err ? 32'd0 : 32'd1);
              if (m.err) n_er++;
              else if (m.we) n_st++;
              else n_ld++;
              void'(q.pop_front());
              seen_v  = 1'b0;
              cs_seen = 0;
            end
          end
        end else if (rst_n) begin
          check(g, "idle_quiet", 32'({bus.resp_valid, bus.mem_cs}), 32'd0);
        end
        bus.resp_ready = rdy_n;
      end
    end

    // Stimulus
    initial begin
      logic [1:0]  sz;
      logic [31:0] a, d;
      bit          rdy, accepted;
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.mem_dout = 32'd0;

      plan.push_back(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, LAT));
      plan.push_back(mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80, LAT));
      plan.push_back(mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80, LAT));
      plan.push_back(mk(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, LAT));
      plan.push_back(mk(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, LAT));
      plan.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h12345678, LAT));
      t = mk(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h8001, LAT);
      t.bp = 5;
      plan.push_back(t);
      t = mk(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'hCAFEF00D, LAT);
      t.rst_mid = 1'b1;
      plan.push_back(t);
      plan.push_back(mk(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 32'hFE, LAT));
      for (int i = 0; i < 60; i++) begin
        sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
        a  = $urandom & 32'hFFF;
        if ($urandom % 4 != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        d = $urandom;
        if (sz == 2'd0) d = d & 32'hFF;
        else if (sz == 2'd1) d = d & 32'hFFFF;
        t = mk(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, d, LAT);
        if ($urandom % 8 == 0) t.bp = 1 + ($urandom % 4);
        plan.push_back(t);
      end

      repeat (3) @(negedge clk);
      #1;
      check(g, "reset_flags", 32'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_cs,
                                   bus.mem_oe, bus.mem_we, bus.mem_sb, bus.mem_sh, bus.mem_lb,
                                   bus.mem_lh, busy}), 32'h400);
      check(g, "reset_rdata", bus.resp_rdata, 32'd0);
      check(g, "reset_mem_addr", bus.mem_addr, 32'd0);
      rst_n = 1'b1;

      foreach (plan[i]) begin
        t = plan[i];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = t.we; bus.req_size = t.size;
        bus.req_signed = t.sgn; bus.req_addr = t.addr; bus.req_wdata = t.wdata;
        bus.mem_dout = t.dout;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
          rdy = bus.req_ready;
          @(posedge clk);
          #1;
          if (rdy) accepted = 1'b1;
          else @(negedge clk);
        end
        if (!accepted) begin
          check(g, "accept_timeout", 32'd0, 32'd1);
          bus.req_valid = 1'b0;
          continue;
        end
        t.acc = cyc;
        hold  = t.bp;
        q.push_back(t);
        // Half the time leave a different request waiting; it must not be taken while busy.
        if ($urandom % 2 == 1) begin
          bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
          bus.req_addr = $urandom; bus.req_wdata = $urandom;
        end else begin
          bus.req_valid = 1'b0;
        end

        if (t.rst_mid) begin
          @(negedge clk);
          @(negedge clk);
          #2;
          rst_n = 1'b0;
          bus.req_valid = 1'b0;
          #1;
          check(g, "midrst_flags", 32'({bus.req_ready, bus.resp_valid, bus.mem_cs, bus.mem_oe,
                                        bus.mem_we, bus.mem_lb, bus.mem_lh, busy}), 32'h80);
          check(g, "midrst_mem_addr", bus.mem_addr, 32'd0);
          q.delete();
          seen_v = 1'b0; cs_seen = 0; hold = 0;
          n_ld = 0; n_st = 0; n_er = 0;
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
          for (int k = 0; k < 100 && q.size() != 0; k++) begin
            @(negedge clk);
            #1;
          end
          bus.req_valid = 1'b0;
          if (q.size() != 0) begin
            check(g, "resp_timeout", 32'(q.size()), 32'd0);
            q.delete();
            seen_v = 1'b0; cs_seen = 0;
          end
        end
      end

      repeat (3) @(negedge clk);
`ifdef MEM_REQ_PERF_CNT_EN
      check(g, "perf_loads", perf_loads, 32'(n_ld));
      check(g, "perf_stores", perf_stores, 32'(n_st));
      check(g, "perf_errs", perf_errs, 32'(n_er));
`endif
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 40000; k++) begin
      if (done[0] && done[1]) break;
      @(posedge clk);
    end
    if (!(done[0] && done[1])) begin
      n_checks++;
      n_fail++;
      $display("FAIL global_timeout: lanes done %0d/%0d, required 1/1", done[0], done[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
